adc045_frame_avg: RTL and testbench
===================================

ADC045_FRAME_AVG -- requirements
Module: adc045_frame_avg

Interface
REQ-001 SHALL have parameter LOG2_N, default 4, meaning log2 of the samples per channel averaged per frame (legal range 1..12).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sync  input  1  one-cycle frame-start strobe from the system.
REQ-005 SHALL have port s_valid  input  1  one-cycle strobe: s_data holds a new conversion from the ADC reader.
REQ-006 SHALL have port s_ch  input  1  channel of s_data (0 = ch1, 1 = ch2), sampled with s_valid.
REQ-007 SHALL have port s_data  input  24  signed two's-complement ADC sample.
REQ-008 SHALL have port avg_ch1  output  24  signed ch1 frame mean.
REQ-009 SHALL have port avg_ch2  output  24  signed ch2 frame mean.
REQ-010 SHALL have port avg_valid  output  1  one-cycle pulse when avg_ch1/avg_ch2 update.
REQ-011 SHALL have port frame_short  output  1  one-cycle pulse when sync aborts an incomplete frame.
REQ-012 SHALL have port frame_cnt  output  16  count of completed frames, wraps 0xFFFF->0x0000.
REQ-013 SHALL have port busy  output  1  high while in ACCUM.

Function
REQ-014 SHALL implement FSM states IDLE and ACCUM; reset state IDLE.
REQ-015 In IDLE, s_valid SHALL be ignored; sync SHALL clear both accumulators/counters and enter ACCUM.
REQ-016 In ACCUM, each s_valid SHALL add sign-extended s_data into the selected channel's (24+LOG2_N)-bit accumulator and increment its count, unless that channel's count already equals 2**LOG2_N, in which case the sample is discarded.
REQ-017 When both channel counts equal 2**LOG2_N, the FSM SHALL return to IDLE, and on the next clock avg_chX SHALL load accumulator >>> LOG2_N (arithmetic, floor), avg_valid SHALL pulse and frame_cnt SHALL increment.
REQ-018 Latency: avg_valid SHALL assert exactly one cycle after the clock edge that accepts the last required sample.
REQ-019 sync in ACCUM with the frame incomplete SHALL pulse frame_short on the next cycle, leave avg_chX and frame_cnt unchanged, clear accumulators and remain in ACCUM (new frame).
REQ-020 sync and s_valid on the same cycle SHALL clear accumulators and count that sample as the first of the new frame.
REQ-021 sync on the same cycle as the frame-completing sample SHALL complete the frame (REQ-017) and also start a new frame with no frame_short.
REQ-022 Accumulators SHALL be wide enough that no overflow occurs at full scale; no saturation logic.
REQ-023 avg_chX SHALL hold value between avg_valid pulses.

Reset
REQ-024 reset SHALL asynchronously force: state IDLE, accumulators and counts 0, avg_ch1=avg_ch2=0, avg_valid=0, frame_short=0, frame_cnt=0, busy=0.
REQ-025 reset asserted mid-frame SHALL discard the partial frame without any pulse on avg_valid or frame_short.

Structure
REQ-026 Package adc045_pkg SHALL hold ADC_W=24, FRAME_CNT_W=16 and the FSM state typedef.
REQ-027 One sub-module adc045_chan_acc (accumulator + count + full flag) SHALL be instantiated twice, once per channel.

Verification (LOG2_N=2, N=4)
REQ-028 Reset asserted -> every output 0, busy 0; s_valid pulses without sync -> no output change.
REQ-029 sync, then interleaved ch1 10,20,30,40 and ch2 -4,-4,-4,-8 -> one cycle after last sample avg_ch1=25, avg_ch2=-5, avg_valid pulse, frame_cnt=1, busy 0.
REQ-030 sync, 2 samples per channel, sync -> frame_short pulse, no avg_valid, next 4+4 samples produce correct averages of the new frame only.
REQ-031 sync, six ch1 samples of 100 then four ch2 of 0x7FFFFF -> extra ch1 discarded, avg_ch1=100, avg_ch2=0x7FFFFF; ch2 all 0x800000 -> avg_ch2=0x800000.
REQ-032 sync coincident with s_valid (ch1=8) followed by three ch1 of 0 and four ch2 of 3 -> avg_ch1=2, avg_ch2=3; frame_cnt preloaded to 0xFFFF wraps to 0x0000.
REQ-033 reset pulsed after 3 samples -> all outputs 0, no pulses; subsequent sync and full frame average correctly.

Source files
------------

// File: rtl/adc045_pkg.sv
// Shared widths and FSM state type for the two-channel ADC frame averager.
package adc045_pkg;

   localparam int ADC_W       = 24;
   localparam int FRAME_CNT_W = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

endpackage

// File: rtl/adc045_chan_acc.sv
// One channel's frame accumulator: sign-extended running sum, sample count and
// full/last flags. acc_sum is the sum including the current sample, unregistered.
module adc045_chan_acc
   import adc045_pkg::*;
#(
   parameter int LOG2_N = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr,
   input  logic                      add,
   input  logic [ADC_W-1:0]          data,
   output logic [ADC_W+LOG2_N-1:0]   acc,
   output logic [ADC_W+LOG2_N-1:0]   acc_sum,
   output logic                      full,
   output logic                      last
);

   localparam int AW = ADC_W + LOG2_N;
   localparam int CW = LOG2_N + 1;
   localparam logic [CW-1:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] data_ext;

   assign data_ext = {{LOG2_N{data[ADC_W-1]}}, data};
   assign acc_sum  = acc_q + data_ext;
   assign acc      = acc_q;
   assign full     = (cnt_q == N_CNT);
   assign last     = (cnt_q == N_CNT - CW'(1));

   // A clear with a sample present restarts the frame with that sample.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         acc_d = add ? data_ext : '0;
         cnt_d = add ? CW'(1) : '0;
      end else if (add && !full) begin
         acc_d = acc_sum;
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adc045_frame_avg.sv
// Two-channel frame averager: accumulates 2**LOG2_N samples per channel between
// sync strobes and publishes the floor mean of each channel once both are full.
module adc045_frame_avg
   import adc045_pkg::*;
#(
   parameter int LOG2_N = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sync,
   input  logic                   s_valid,
   input  logic                   s_ch,
   input  logic [ADC_W-1:0]       s_data,
   output logic [ADC_W-1:0]       avg_ch1,
   output logic [ADC_W-1:0]       avg_ch2,
   output logic                   avg_valid,
   output logic                   frame_short,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   busy
);

   localparam int AW = ADC_W + LOG2_N;

   state_e                 state_q, state_d;
   logic                   done_q, done_d;
   logic                   short_q, short_d;
   logic                   avg_valid_q, avg_valid_d;
   logic [AW-1:0]          pend1_q, pend1_d;
   logic [AW-1:0]          pend2_q, pend2_d;
   logic [ADC_W-1:0]       avg1_q, avg1_d;
   logic [ADC_W-1:0]       avg2_q, avg2_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic          clr, add1, add2;
   logic          hit1, hit2;
   logic [AW-1:0] acc1, acc2, sum1, sum2;
   logic          full1, full2, last1, last2;
   logic          done1, done2, complete;
   logic          unused_lsbs;

   adc045_chan_acc #(.LOG2_N(LOG2_N)) u_ch1 (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .add     (add1),
      .data    (s_data),
      .acc     (acc1),
      .acc_sum (sum1),
      .full    (full1),
      .last    (last1)
   );

   adc045_chan_acc #(.LOG2_N(LOG2_N)) u_ch2 (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .add     (add2),
      .data    (s_data),
      .acc     (acc2),
      .acc_sum (sum2),
      .full    (full2),
      .last    (last2)
   );

   assign hit1     = s_valid && !s_ch;
   assign hit2     = s_valid && s_ch;
   assign done1    = full1 || (hit1 && last1);
   assign done2    = full2 || (hit2 && last2);
   assign complete = (state_q == ST_ACCUM) && done1 && done2;

   // The finished sums are snapshotted on the completing edge so a coincident
   // sync can clear the accumulators for the next frame without losing them.
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      add1    = 1'b0;
      add2    = 1'b0;
      done_d  = 1'b0;
      short_d = 1'b0;
      pend1_d = pend1_q;
      pend2_d = pend2_q;
      case (state_q)
         ST_IDLE: begin
            if (sync) begin
               clr     = 1'b1;
               add1    = hit1;
               add2    = hit2;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (complete) begin
               done_d  = 1'b1;
               pend1_d = (hit1 && last1) ? sum1 : acc1;
               pend2_d = (hit2 && last2) ? sum2 : acc2;
               if (sync) begin
                  clr = 1'b1;
               end else begin
                  add1    = hit1;
                  add2    = hit2;
                  state_d = ST_IDLE;
               end
            end else begin
               add1 = hit1;
               add2 = hit2;
               if (sync) begin
                  clr     = 1'b1;
                  short_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Taking the upper bits of the sign-extended sum is an arithmetic shift,
   // so the mean rounds toward negative infinity.
   always_comb begin
      avg_valid_d = done_q;
      avg1_d      = avg1_q;
      avg2_d      = avg2_q;
      frame_cnt_d = frame_cnt_q;
      if (done_q) begin
         avg1_d      = pend1_q[AW-1:LOG2_N];
         avg2_d      = pend2_q[AW-1:LOG2_N];
         frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end
   end

   // Remainder bits discarded by the floor division.
   assign unused_lsbs = ^{pend1_q[LOG2_N-1:0], pend2_q[LOG2_N-1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         avg_valid_q <= 1'b0;
         pend1_q     <= '0;
         pend2_q     <= '0;
         avg1_q      <= '0;
         avg2_q      <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         short_q     <= short_d;
         avg_valid_q <= avg_valid_d;
         pend1_q     <= pend1_d;
         pend2_q     <= pend2_d;
         avg1_q      <= avg1_d;
         avg2_q      <= avg2_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign avg_ch1     = avg1_q;
   assign avg_ch2     = avg2_q;
   assign avg_valid   = avg_valid_q;
   assign frame_short = short_q;
   assign frame_cnt   = frame_cnt_q;
   assign busy        = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_adc045_frame_avg.sv
// Self-checking bench for adc045_frame_avg with LOG2_N=2 (four samples per channel).
module tb_adc045_frame_avg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sync = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ch = 1'b0;
   logic [23:0] s_data = '0;
   logic [23:0] avg_ch1, avg_ch2;
   logic        avg_valid, frame_short, busy;
   logic [15:0] frame_cnt;

   adc045_frame_avg #(.LOG2_N(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .sync        (sync),
      .s_valid     (s_valid),
      .s_ch        (s_ch),
      .s_data      (s_data),
      .avg_ch1     (avg_ch1),
      .avg_ch2     (avg_ch2),
      .avg_valid   (avg_valid),
      .frame_short (frame_short),
      .frame_cnt   (frame_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [0:3][23:0] c1;
      logic [0:3][23:0] c2;
      logic [23:0]      e1;
      logic [23:0]      e2;
   } vec_t;

   localparam int NV = 5;
   vec_t tbl [NV];

   logic [63:0] exp_q [$];
   logic [63:0] mon_r;
   logic [23:0] hold1 = '0, hold2 = '0;
   logic [15:0] hold_fc = '0, model_fc = '0;
   int          checks = 0, failures = 0, short_seen = 0, short_base;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Output monitor: pops expected frames on avg_valid, otherwise outputs must hold.
   always @(negedge clk) begin
      if (frame_short) short_seen++;
      if (avg_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_avg_valid", 32'd1, 32'd0);
         end else begin
            mon_r = exp_q.pop_front();
            chk("avg_ch1", 32'(avg_ch1), 32'(mon_r[63:40]));
            chk("avg_ch2", 32'(avg_ch2), 32'(mon_r[39:16]));
            chk("frame_cnt", 32'(frame_cnt), 32'(mon_r[15:0]));
            hold1   = mon_r[63:40];
            hold2   = mon_r[39:16];
            hold_fc = mon_r[15:0];
         end
      end else begin
         chk("hold_ch1", 32'(avg_ch1), 32'(hold1));
         chk("hold_ch2", 32'(avg_ch2), 32'(hold2));
         chk("hold_frame_cnt", 32'(frame_cnt), 32'(hold_fc));
      end
   end

   task automatic cyc(input logic sy, input logic v, input logic c, input logic [23:0] d);
      sync    = sy;
      s_valid = v;
      s_ch    = c;
      s_data  = d;
      @(posedge clk);
      #1;
      sync    = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic expect_frame(input logic [23:0] e1, input logic [23:0] e2);
      model_fc = model_fc + 16'd1;
      exp_q.push_back({e1, e2, model_fc});
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input vec_t v);
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, v.c1[i]);
         if (i == 3) expect_frame(v.e1, v.e2);
         cyc(1'b0, 1'b1, 1'b1, v.c2[i]);
      end
      drain();
   endtask

   task automatic check_all_zero(input string tag);
      @(negedge clk);
      chk({tag, "_avg_ch1"}, 32'(avg_ch1), 32'd0);
      chk({tag, "_avg_ch2"}, 32'(avg_ch2), 32'd0);
      chk({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
      chk({tag, "_frame_short"}, 32'(frame_short), 32'd0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic pulse_reset();
      reset   = 1'b1;
      hold1   = '0;
      hold2   = '0;
      hold_fc = '0;
      model_fc = '0;
      exp_q.delete();
      check_all_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{c1: {24'd10, 24'd20, 24'd30, 24'd40},
                 c2: {24'hFFFFFC, 24'hFFFFFC, 24'hFFFFFC, 24'hFFFFF8},
                 e1: 24'd25, e2: 24'hFFFFFB};
      tbl[1] = '{c1: {24'd1, 24'd2, 24'd3, 24'd4},
                 c2: {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE},
                 e1: 24'd2, e2: 24'hFFFFFE};
      tbl[2] = '{c1: {24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF},
                 c2: {24'h800000, 24'h800000, 24'h800000, 24'h800000},
                 e1: 24'h7FFFFF, e2: 24'h800000};
      tbl[3] = '{c1: {24'd0, 24'd0, 24'd0, 24'd3},
                 c2: {24'd1, 24'd1, 24'd1, 24'd0},
                 e1: 24'd0, e2: 24'd0};
      tbl[4] = '{c1: {24'hFFFFFD, 24'd0, 24'd0, 24'd0},
                 c2: {24'd100, 24'd200, 24'd300, 24'd400},
                 e1: 24'hFFFFFF, e2: 24'd250};

      // Reset state, then samples without sync must be ignored.
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("init");
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, 24'h000123);
      cyc(1'b0, 1'b1, 1'b1, 24'h000456);
      cyc(1'b0, 1'b1, 1'b0, 24'h000789);
      check_all_zero("idle_ignore");
      @(posedge clk);
      #1;

      // Basic frame with explicit latency and busy checks.
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      @(negedge clk);
      chk("busy_after_sync", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, tbl[0].c1[i]);
         if (i == 3) expect_frame(tbl[0].e1, tbl[0].e2);
         cyc(1'b0, 1'b1, 1'b1, tbl[0].c2[i]);
      end
      @(negedge clk);
      chk("lat_early_avg_valid", 32'(avg_valid), 32'd0);
      chk("busy_after_complete", 32'(busy), 32'd0);
      @(negedge clk);
      chk("lat_avg_valid", 32'(avg_valid), 32'd1);
      @(posedge clk);
      #1;
      drain();

      for (int k = 1; k < NV; k++) run_frame(tbl[k]);

      // Aborted frame: sync mid-frame pulses frame_short and restarts.
      short_base = short_seen;
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      cyc(1'b0, 1'b1, 1'b0, 24'd5);
      cyc(1'b0, 1'b1, 1'b1, 24'd6);
      cyc(1'b0, 1'b1, 1'b0, 24'd7);
      cyc(1'b0, 1'b1, 1'b1, 24'd8);
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      @(negedge clk);
      chk("frame_short_pulse", 32'(frame_short), 32'd1);
      chk("busy_after_abort", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, (i == 3) ? 24'd16 : 24'd12);
         if (i == 3) expect_frame(24'd13, 24'hFFFFFF);
         cyc(1'b0, 1'b1, 1'b1, 24'hFFFFFF);
      end
      drain();
      chk("short_count_abort", 32'(short_seen - short_base), 32'd1);

      // Surplus ch1 samples are discarded; full-scale extremes.
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 24'd100);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expect_frame(24'd100, 24'h7FFFFF);
         cyc(1'b0, 1'b1, 1'b1, 24'h7FFFFF);
      end
      drain();
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 24'h800000);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expect_frame(24'd0, 24'h800000);
         cyc(1'b0, 1'b1, 1'b0, 24'd0);
      end
      drain();

      // sync with a sample starts the frame with it; frame_cnt wraps.
      force dut.frame_cnt_q = 16'hFFFF;
      hold_fc  = 16'hFFFF;
      model_fc = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.frame_cnt_q;
      cyc(1'b1, 1'b1, 1'b0, 24'd8);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 24'd0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expect_frame(24'd2, 24'd3);
         cyc(1'b0, 1'b1, 1'b1, 24'd3);
      end
      drain();
      chk("frame_cnt_wrapped", 32'(frame_cnt), 32'd0);

      // sync on the completing sample: frame completes and a fresh one starts.
      short_base = short_seen;
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 24'd4);
         if (i == 3) begin
            expect_frame(24'd4, 24'd8);
            cyc(1'b1, 1'b1, 1'b1, 24'd8);
         end else begin
            cyc(1'b0, 1'b1, 1'b1, 24'd8);
         end
      end
      @(negedge clk);
      chk("busy_after_sync_complete", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 24'd2);
         if (i == 3) expect_frame(24'd2, 24'd0);
         cyc(1'b0, 1'b1, 1'b1, 24'd0);
      end
      drain();
      chk("short_count_sync_complete", 32'(short_seen - short_base), 32'd0);

      // Reset mid-frame discards the partial frame silently.
      short_base = short_seen;
      cyc(1'b1, 1'b0, 1'b0, 24'd0);
      cyc(1'b0, 1'b1, 1'b0, 24'd50);
      cyc(1'b0, 1'b1, 1'b1, 24'd60);
      cyc(1'b0, 1'b1, 1'b0, 24'd70);
      pulse_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("short_count_reset", 32'(short_seen - short_base), 32'd0);
      run_frame(tbl[0]);
      chk("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);

      drain();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("short_total", 32'(short_seen), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
